// File: rtl/conversor_pkg.sv
// conversor_pkg: shared state encoding and defaults for the converter sequencer.
package conversor_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, LATCH, CAPTURE, VALID} state_t;
  localparam int N_DEFAULT = 4;
  localparam int TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/conversor_ctrl.sv
// conversor_ctrl: frames clear/shift/latch/capture for a serial-to-parallel converter.
// Optional SHIFT idle abort enabled by defining CONVERSOR_TIMEOUT_EN.
module conversor_ctrl
  import conversor_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic         bit_valid,
  input  logic [N-1:0] par_in,
  output logic         ctl_a,
  output logic         ctl_b,
  output logic         ctl_c,
  output logic [N-1:0] word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         busy,
  output logic         overrun,
  output logic         timeout
);
  localparam int BW = $clog2(N + 1);
  state_t state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [N-1:0] word_q, word_d;
  logic valid_q, valid_d, overrun_q, overrun_d, expire, last;

`ifdef CONVERSOR_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;
  assign expire = state_q == SHIFT && !bit_valid && idle_q == IW'(TIMEOUT - 1);
  assign idle_d = (state_q == SHIFT && !bit_valid && !expire) ? idle_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idle_q <= '0;
    else idle_q <= idle_d;
`else
  assign expire = 1'b0 && TIMEOUT > 0;
`endif

  assign last = cnt_q == BW'(N - 1);
  assign busy = state_q != IDLE;
  assign ctl_a = state_q == CLEAR || expire;
  assign ctl_b = state_q == SHIFT && bit_valid;
  assign ctl_c = state_q == LATCH;
  assign timeout = expire;
  assign word_out = word_q;
  assign word_valid = valid_q;
  assign overrun = overrun_q;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    word_d = word_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: state_d = req ? CLEAR : IDLE;
      CLEAR: begin
        state_d = SHIFT;
        cnt_d = '0;
      end
      SHIFT: begin
        if (expire) state_d = IDLE;
        else if (bit_valid) begin
          cnt_d = last ? '0 : cnt_q + 1'b1;
          state_d = last ? LATCH : SHIFT;
        end
      end
      LATCH: state_d = CAPTURE;
      CAPTURE: begin
        word_d = par_in;
        valid_d = 1'b1;
        state_d = VALID;
      end
      VALID: begin
        if (word_ready) begin
          valid_d = 1'b0;
          state_d = req ? CLEAR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a strobe outside SHIFT is lost; the flag restarts with each new frame
    overrun_d = (state_d == CLEAR && state_q != CLEAR) ? 1'b0
              : overrun_q | (busy && state_q != SHIFT && bit_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      word_q <= '0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
    end
  end
endmodule

// File: tb/tb_conversor_ctrl.sv
// tb_conversor_ctrl: directed frames against a converter model with a word scoreboard.
module tb_conversor_ctrl;
  logic clk = 0, rst_n = 0, req = 0, bit_valid = 0, in_ser = 0, word_ready = 0;
  logic ctl_a, ctl_b, ctl_c, word_valid, busy, overrun, timeout;
  logic [3:0] par_in, word_out, sr;
  logic [3:0] exp_q[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  conversor_ctrl #(.N(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .bit_valid(bit_valid), .par_in(par_in),
    .ctl_a(ctl_a), .ctl_b(ctl_b), .ctl_c(ctl_c), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .busy(busy),
    .overrun(overrun), .timeout(timeout)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      par_in <= '0;
    end else begin
      if (ctl_a) sr <= '0;
      else if (ctl_b) sr <= {sr[2:0], in_ser};
      if (ctl_c) par_in <= sr;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_frame(input logic [3:0] w, input int nbits);
    int i;
    for (i = 0; i < 20 && !ctl_a; i++) @(negedge clk);
    chk("clear_seen", {31'd0, ctl_a}, 1);
    chk("clear_ctl", {ctl_a, ctl_b, ctl_c, busy}, 4'b1001);
    @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      bit_valid = 1;
      in_ser = w[3-k];
      #1 chk("shift_ctl", {ctl_a, ctl_b, ctl_c}, 3'b010);
      @(negedge clk);
    end
    bit_valid = 0;
    if (nbits == 4) begin
      #1 chk("latch_ctl", {ctl_a, ctl_b, ctl_c}, 3'b001);
      exp_q.push_back(w);
    end
  endtask

  task automatic take_word(input int hold);
    int i;
    logic [3:0] w0, e;
    for (i = 0; i < 20 && !word_valid; i++) @(negedge clk);
    chk("valid_seen", {31'd0, word_valid}, 1);
    w0 = word_out;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_stable", {word_valid, word_out}, {1'b1, w0});
    end
    word_ready = 1;
    e = exp_q.size() ? exp_q.pop_front() : 4'hx;
    chk("word", {28'd0, word_out}, {28'd0, e});
    @(negedge clk);
    word_ready = 0;
    chk("valid_drop", {31'd0, word_valid}, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("reset_idle", {ctl_a, ctl_b, ctl_c, word_valid, busy, overrun, timeout, word_out}, 0);
    end
    req = 1;
    @(negedge clk);
    req = 0;
    send_frame(4'b1011, 4);
    @(negedge clk);
    chk("capture_ctl", {ctl_a, ctl_b, ctl_c, word_valid}, 0);
    @(negedge clk);
    chk("latency_valid", {27'd0, word_valid, word_out}, 5'b11011);
    take_word(0);
    chk("back_idle", {31'd0, busy}, 0);
    req = 1;
    send_frame(4'b0110, 4);
    take_word(5);
    chk("b2b_clear", {ctl_a, busy}, 2'b11);
    send_frame(4'b1100, 4);
    bit_valid = 1;
    in_ser = 1;
    #1 chk("latch_no_shift", {31'd0, ctl_b}, 0);
    @(negedge clk);
    bit_valid = 0;
    chk("overrun_set", {31'd0, overrun}, 1);
    take_word(1);
    chk("overrun_clear", {ctl_a, overrun}, 2'b10);
    send_frame(4'b1010, 2);
    rst_n = 0;
    req = 0;
    #1 chk("reset_mid", {ctl_a, ctl_b, ctl_c, word_valid, busy, overrun, timeout, word_out}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    req = 1;
    send_frame(4'b1001, 4);
    req = 0;
    take_word(2);
    chk("final_idle", {busy, overrun, timeout}, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
